// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester packet arbiter.
// Holds the arbiter state encoding, the mux select values and the
// default packet length limit. Every file that needs them imports this
// package.
package mux_arb_pkg;

    // Arbiter FSM states.
    //   IDLE    : nothing is granted; arbitration happens here.
    //   GRANT_A : requester A owns the output until its packet ends.
    //   GRANT_B : requester B owns the output until its packet ends.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    // Mux select values.
    // SEL_A also records "A was served last" in the last-grant flag.
    // SEL_B also records "B was served last" in the last-grant flag.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Default packet length limit. A packet that reaches this many
    // beats without a last beat loses its grant.
    localparam int DEFAULT_MAX_BEATS = 16;

endpackage : mux_arb_pkg

// File: rtl/mux_2to1_bus.sv
// WIDTH-wide payload and last-flag selector.
// Both requesters' data and last flags go through this block. sel picks
// which requester reaches the output. When sel = SEL_A (IDLE and
// GRANT_A) the output shows A. This keeps y_data at A's payload
// whenever nothing is granted.
module mux_2to1_bus
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last
);

    // Pure combinational select. No state lives here.
    always_comb begin
        if (sel == SEL_B) begin
            y_data = b_data;
            y_last = b_last;
        end else begin
            y_data = a_data;
            y_last = a_last;
        end
    end

endmodule : mux_2to1_bus

// File: rtl/mux_2to1_arbiter.sv
// Two-requester packet arbiter with a zero-latency output path.
//
// Handshake contract, used on every port pair:
//   - A beat moves on a rising edge only if valid && ready are both
//     high in the cycle before that edge.
//   - A source must hold its payload stable until the beat moves.
//   - ready here is combinational.
//     * The granted requester sees y_ready directly.
//     * The other requester always sees ready = 0.
//     * Both readies are 0 in IDLE and while rst_n is low.
//     * So no beat can move in a reset cycle.
//
// Once a requester wins, it keeps the grant until one of these happens:
//   - it sends a last beat, or
//   - it reaches MAX_BEATS accepted beats without a last beat.
// In the second case the grant is taken back and err_overrun pulses
// for one cycle.
// Every packet end returns through IDLE. This gives one bubble cycle
// before the next grant.
module mux_2to1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = DEFAULT_MAX_BEATS
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,

    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,

    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last,
    input  logic             y_ready,

    output logic             sel,
    output logic             err_overrun
);

    // Counter wide enough to hold MAX_BEATS itself.
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          last_grant_q;    // SEL_A or SEL_B: who was granted last
    logic          last_grant_d;
    logic [CW-1:0] beat_cnt_q;      // beats accepted in the current packet
    logic [CW-1:0] beat_cnt_d;
    logic          err_q;
    logic          err_d;

    // ------------------------------------------------------------------
    // Datapath and handshake signals
    // ------------------------------------------------------------------
    logic          in_grant_a;
    logic          in_grant_b;
    logic          granted_valid;   // valid of whichever requester owns the grant
    logic          accept;          // a beat moves on the next edge
    logic [CW-1:0] beat_cnt_inc;

    assign in_grant_a = (state_q == GRANT_A);
    assign in_grant_b = (state_q == GRANT_B);

    // sel is decoded from the registered state only.
    // It can therefore change only when the state changes.
    assign sel = in_grant_b ? SEL_B : SEL_A;

    // Payload and last flag come from the selector sub-module.
    mux_2to1_bus #(
        .WIDTH (WIDTH)
    ) u_bus (
        .sel    (sel),
        .a_data (a_data),
        .a_last (a_last),
        .b_data (b_data),
        .b_last (b_last),
        .y_data (y_data),
        .y_last (y_last)
    );

    // Handshake gating.
    // rst_n is folded in so that a packet interrupted by reset cannot
    // hand over a beat during the reset cycle.
    always_comb begin
        granted_valid = 1'b0;
        if (in_grant_a) begin
            granted_valid = a_valid;
        end else if (in_grant_b) begin
            granted_valid = b_valid;
        end
        y_valid = rst_n && granted_valid;
        a_ready = rst_n && in_grant_a && y_ready;
        b_ready = rst_n && in_grant_b && y_ready;
        accept  = y_valid && y_ready;
    end

    assign beat_cnt_inc = beat_cnt_q + CNT_ONE;

    // Next-state logic, covering:
    //   - arbitration in IDLE;
    //   - packet end and overrun detection in the grant states.
    // A stall (y_ready = 0) or a gap (valid = 0) means no accept.
    // In that case everything simply holds.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                // Clear here so every grant starts counting from zero.
                beat_cnt_d = '0;
                if (a_valid && b_valid) begin
                    // Tie: serve whoever was not served last.
                    if (last_grant_q == SEL_B) begin
                        state_d      = GRANT_A;
                        last_grant_d = SEL_A;
                    end else begin
                        state_d      = GRANT_B;
                        last_grant_d = SEL_B;
                    end
                end else if (a_valid) begin
                    state_d      = GRANT_A;
                    last_grant_d = SEL_A;
                end else if (b_valid) begin
                    state_d      = GRANT_B;
                    last_grant_d = SEL_B;
                end
            end

            GRANT_A, GRANT_B: begin
                if (accept) begin
                    if (y_last) begin
                        // Normal end. This includes a last beat that is
                        // exactly beat MAX_BEATS: no error in that case.
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end else if (beat_cnt_inc == MAX_CNT) begin
                        // Packet hit the limit without a last beat.
                        // Take the grant back and flag it.
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        err_d      = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_inc;
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // State update with synchronous active-low reset.
    // Reset sets last_grant to B, so A wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= SEL_B;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
        end
    end

    assign err_overrun = err_q;

endmodule : mux_2to1_arbiter

// File: tb/tb_mux_2to1_arbiter.sv
// Bench for mux_2to1_arbiter.
// Inputs change 1 time unit after the rising edge.
// Outputs are sampled on the falling edge.
// A scoreboard holds {sel, last, data} for every beat expected at the
// output, in order.
module tb_mux_2to1_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_last;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_last;
    logic             b_ready;
    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_last;
    logic             y_ready;
    logic             sel;
    logic             err_overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [WIDTH+1:0] exp_q[$];
    int               acc_log[$];

    mux_2to1_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BEATS (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_data      (a_data),
        .a_last      (a_last),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_data      (b_data),
        .b_last      (b_last),
        .b_ready     (b_ready),
        .y_valid     (y_valid),
        .y_data      (y_data),
        .y_last      (y_last),
        .y_ready     (y_ready),
        .sel         (sel),
        .err_overrun (err_overrun)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard monitor ----------------
    // A beat seen here with valid && ready moves on the next edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && y_valid === 1'b1 && y_ready === 1'b1) begin
            acc_log.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got sel/last/data %b/%b/%h, expected no beat",
                         sel, y_last, y_data);
            end else begin
                logic [WIDTH+1:0] exp_v;
                exp_v = exp_q.pop_front();
                if ({sel, y_last, y_data} !== exp_v) begin
                    n_fail++;
                    $display("FAIL beat_order: got sel/last/data %b/%b/%h, expected %b/%b/%h",
                             sel, y_last, y_data, exp_v[WIDTH+1], exp_v[WIDTH], exp_v[WIDTH-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input logic s, input logic l, input logic [WIDTH-1:0] d);
        exp_q.push_back({s, l, d});
    endtask

    task automatic send_a(input int n, input logic [WIDTH-1:0] base, input bit close);
        for (int i = 0; i < n; i++) begin
            int  waited;
            bit  done;
            waited  = 0;
            done    = 0;
            a_valid = 1'b1;
            a_data  = base + WIDTH'(i);
            a_last  = close && (i == n - 1);
            while (!done) begin
                @(negedge clk);
                if (a_ready === 1'b1 && rst_n === 1'b1) begin
                    done = 1;
                end else begin
                    waited++;
                    if (waited > 100) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL a_timeout: got no a_ready in 100 cycles, expected acceptance of %h", a_data);
                        a_valid = 1'b0;
                        a_last  = 1'b0;
                        @(posedge clk);
                        #1;
                        return;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    task automatic send_b(input int n, input logic [WIDTH-1:0] base, input bit close);
        for (int i = 0; i < n; i++) begin
            int  waited;
            bit  done;
            waited  = 0;
            done    = 0;
            b_valid = 1'b1;
            b_data  = base + WIDTH'(i);
            b_last  = close && (i == n - 1);
            while (!done) begin
                @(negedge clk);
                if (b_ready === 1'b1 && rst_n === 1'b1) begin
                    done = 1;
                end else begin
                    waited++;
                    if (waited > 100) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL b_timeout: got no b_ready in 100 cycles, expected acceptance of %h", b_data);
                        b_valid = 1'b0;
                        b_last  = 1'b0;
                        @(posedge clk);
                        #1;
                        return;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        b_valid = 1'b0;
        b_last  = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n   = 1'b0;
        a_valid = 1'b0;
        a_data  = 8'h5A;
        a_last  = 1'b0;
        b_valid = 1'b0;
        b_data  = 8'hA5;
        b_last  = 1'b0;
        y_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks += 6;
        if (y_valid !== 1'b0) begin n_fail++; $display("FAIL rst_y_valid: got %b expected 0", y_valid); end
        if (a_ready !== 1'b0) begin n_fail++; $display("FAIL rst_a_ready: got %b expected 0", a_ready); end
        if (b_ready !== 1'b0) begin n_fail++; $display("FAIL rst_b_ready: got %b expected 0", b_ready); end
        if (sel !== 1'b0) begin n_fail++; $display("FAIL rst_sel: got %b expected 0", sel); end
        if (y_data !== 8'h5A) begin n_fail++; $display("FAIL rst_y_data: got %h expected 5a", y_data); end
        if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err_overrun); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_tie_order();
        int base;
        base = acc_log.size();
        push_exp(1'b0, 1'b0, 8'h11);
        push_exp(1'b0, 1'b1, 8'h12);
        push_exp(1'b1, 1'b0, 8'h21);
        push_exp(1'b1, 1'b1, 8'h22);
        fork
            send_a(2, 8'h11, 1'b1);
            send_b(2, 8'h21, 1'b1);
        join
        n_checks++;
        if (acc_log.size() < base + 4) begin
            n_fail++;
            $display("FAIL tie_beats: got %0d beats, expected 4", acc_log.size() - base);
        end else begin
            n_checks += 2;
            if (acc_log[base+1] - acc_log[base] !== 1) begin
                n_fail++;
                $display("FAIL tie_a_spacing: got %0d cycles, expected 1", acc_log[base+1] - acc_log[base]);
            end
            if (acc_log[base+2] - acc_log[base+1] !== 2) begin
                n_fail++;
                $display("FAIL tie_bubble: got %0d cycles, expected 2", acc_log[base+2] - acc_log[base+1]);
            end
            if (acc_log[base+3] - acc_log[base+2] !== 1) begin
                n_fail++;
                $display("FAIL tie_b_spacing: got %0d cycles, expected 1", acc_log[base+3] - acc_log[base+2]);
            end
        end
    endtask

    task automatic test_b_then_tie();
        push_exp(1'b1, 1'b0, 8'h31);
        push_exp(1'b1, 1'b0, 8'h32);
        push_exp(1'b1, 1'b1, 8'h33);
        send_b(3, 8'h31, 1'b1);
        push_exp(1'b0, 1'b1, 8'h41);
        push_exp(1'b1, 1'b1, 8'h51);
        fork
            send_a(1, 8'h41, 1'b1);
            send_b(1, 8'h51, 1'b1);
            begin
                @(negedge clk);
                @(negedge clk);
                n_checks += 3;
                if (sel !== 1'b0) begin n_fail++; $display("FAIL rr_sel: got %b expected 0", sel); end
                if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rr_a_ready: got %b expected 1", a_ready); end
                if (b_ready !== 1'b0) begin n_fail++; $display("FAIL rr_b_ready: got %b expected 0", b_ready); end
            end
        join
    endtask

    task automatic test_stall();
        push_exp(1'b0, 1'b0, 8'h61);
        push_exp(1'b0, 1'b0, 8'h62);
        push_exp(1'b0, 1'b1, 8'h63);
        push_exp(1'b1, 1'b1, 8'h71);
        fork
            send_a(3, 8'h61, 1'b1);
            send_b(1, 8'h71, 1'b1);
            begin
                logic [WIDTH-1:0] held;
                @(negedge clk);
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                y_ready = 1'b0;
                @(negedge clk);
                held = y_data;
                n_checks += 4;
                if (y_data !== 8'h62) begin n_fail++; $display("FAIL stall_data: got %h expected 62", y_data); end
                if (y_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b expected 1", y_valid); end
                if (a_ready !== 1'b0) begin n_fail++; $display("FAIL stall_a_ready: got %b expected 0", a_ready); end
                if (b_ready !== 1'b0) begin n_fail++; $display("FAIL stall_b_ready: got %b expected 0", b_ready); end
                @(posedge clk);
                #1;
                @(negedge clk);
                n_checks += 3;
                if (y_data !== held) begin n_fail++; $display("FAIL stall_hold: got %h expected %h", y_data, held); end
                if (a_ready !== 1'b0) begin n_fail++; $display("FAIL stall2_a_ready: got %b expected 0", a_ready); end
                if (b_ready !== 1'b0) begin n_fail++; $display("FAIL stall2_b_ready: got %b expected 0", b_ready); end
                @(posedge clk);
                #1;
                y_ready = 1'b1;
                @(negedge clk);
                n_checks += 2;
                if (a_ready !== 1'b1) begin n_fail++; $display("FAIL resume_a_ready: got %b expected 1", a_ready); end
                if (b_ready !== 1'b0) begin n_fail++; $display("FAIL resume_b_ready: got %b expected 0", b_ready); end
                @(posedge clk);
                #1;
            end
        join
    endtask

    task automatic test_overrun();
        int start;
        int pulses;
        int err_cyc;
        start   = acc_log.size();
        pulses  = 0;
        err_cyc = -1;
        for (int i = 0; i < 16; i++) push_exp(1'b0, 1'b0, 8'h80 + WIDTH'(i));
        push_exp(1'b1, 1'b1, 8'hB1);
        push_exp(1'b0, 1'b1, 8'h90);
        fork
            send_a(17, 8'h80, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #1;
                send_b(1, 8'hB1, 1'b1);
            end
            begin
                repeat (40) begin
                    @(negedge clk);
                    if (err_overrun === 1'b1) begin
                        pulses++;
                        err_cyc = cyc;
                        n_checks += 3;
                        if (y_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_idle_valid: got %b expected 0", y_valid); end
                        if (a_ready !== 1'b0) begin n_fail++; $display("FAIL ovr_idle_a_ready: got %b expected 0", a_ready); end
                        if (b_ready !== 1'b0) begin n_fail++; $display("FAIL ovr_idle_b_ready: got %b expected 0", b_ready); end
                    end
                end
            end
        join
        @(posedge clk);
        #1;
        n_checks += 2;
        if (pulses !== 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d expected 1", pulses); end
        if (acc_log.size() < start + 16) begin
            n_fail++;
            $display("FAIL ovr_timing: got %0d beats, expected at least 16", acc_log.size() - start);
        end else if (err_cyc !== acc_log[start+15] + 1) begin
            n_fail++;
            $display("FAIL ovr_timing: got err at cycle %0d, expected %0d", err_cyc, acc_log[start+15] + 1);
        end
    endtask

    task automatic test_last_at_max();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 15; i++) push_exp(1'b0, 1'b0, 8'hA0 + WIDTH'(i));
        push_exp(1'b0, 1'b1, 8'hAF);
        fork
            send_a(16, 8'hA0, 1'b1);
            begin
                repeat (30) begin
                    @(negedge clk);
                    if (err_overrun === 1'b1) pulses++;
                end
            end
        join
        @(posedge clk);
        #1;
        n_checks++;
        if (pulses !== 0) begin n_fail++; $display("FAIL max_last_err: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_reset_mid();
        push_exp(1'b0, 1'b0, 8'hC1);
        a_valid = 1'b1;
        a_data  = 8'hC1;
        a_last  = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_grant: got %b expected 1", a_ready); end
        @(posedge clk);
        #1;
        a_data = 8'hC2;
        rst_n  = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (a_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_no_accept: got %b expected 0", a_ready); end
        if (y_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_y_valid: got %b expected 0", y_valid); end
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        a_valid = 1'b0;
        @(negedge clk);
        n_checks += 4;
        if (sel !== 1'b0) begin n_fail++; $display("FAIL rmid_sel: got %b expected 0", sel); end
        if (a_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_a_ready: got %b expected 0", a_ready); end
        if (b_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_b_ready: got %b expected 0", b_ready); end
        if (y_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_idle_valid: got %b expected 0", y_valid); end
        @(posedge clk);
        #1;
        push_exp(1'b0, 1'b0, 8'hD1);
        push_exp(1'b0, 1'b1, 8'hD2);
        send_a(2, 8'hD1, 1'b1);
    endtask

    task automatic test_gap();
        push_exp(1'b0, 1'b0, 8'hE1);
        push_exp(1'b0, 1'b0, 8'hE2);
        push_exp(1'b0, 1'b0, 8'hE3);
        push_exp(1'b0, 1'b1, 8'hE4);
        push_exp(1'b1, 1'b1, 8'hE9);
        fork
            begin
                send_a(2, 8'hE1, 1'b0);
                repeat (3) begin
                    @(negedge clk);
                    n_checks += 3;
                    if (y_valid !== 1'b0) begin n_fail++; $display("FAIL gap_y_valid: got %b expected 0", y_valid); end
                    if (b_ready !== 1'b0) begin n_fail++; $display("FAIL gap_b_ready: got %b expected 0", b_ready); end
                    if (sel !== 1'b0) begin n_fail++; $display("FAIL gap_sel: got %b expected 0", sel); end
                    @(posedge clk);
                    #1;
                end
                send_a(2, 8'hE3, 1'b1);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                send_b(1, 8'hE9, 1'b1);
            end
        join
    endtask

    // ---------------- sequencer and report ----------------
    initial begin
        test_reset();
        test_tie_order();
        test_b_then_tie();
        test_stall();
        test_overrun();
        test_last_at_max();
        test_reset_mid();
        test_gap();
        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_beats: got %0d unmatched, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mux_2to1_arbiter

// File: doc/mux_2to1_arbiter.md
MUX_2TO1_ARBITER -- requirements
Module: mux_2to1_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: payload width of each requester and the output, in bits.
REQ-002 Parameter MAX_BEATS, default 16: maximum beats per packet before the grant is forcibly released.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 a_valid  in  1  requester A beat valid.
REQ-007 a_data  in  WIDTH  requester A payload.
REQ-008 a_last  in  1  requester A final beat of packet.
REQ-009 a_ready  out  1  requester A beat accepted when a_valid && a_ready.
REQ-010 b_valid, b_data, b_last, b_ready SHALL mirror REQ-006 to REQ-009 for requester B.
REQ-011 y_valid  out  1  output beat valid.
REQ-012 y_data  out  WIDTH  output payload.
REQ-013 y_last  out  1  output final beat.
REQ-014 y_ready  in  1  downstream accepts when y_valid && y_ready.
REQ-015 sel  out  1  current mux select: 0 = A, 1 = B.
REQ-016 err_overrun  out  1  one-cycle pulse on a forced release.

Function
REQ-017 FSM states SHALL be IDLE, GRANT_A and GRANT_B.
REQ-018 In IDLE: y_valid = 0, a_ready = 0, b_ready = 0.
REQ-019 IDLE arbitration: a_valid only -> GRANT_A next edge; b_valid only -> GRANT_B next edge; neither -> stay in IDLE.
REQ-020 IDLE tie (both valid): grant the requester not served last, using last_grant; the new grant then updates last_grant.
REQ-021 Arbitration latency SHALL be one cycle, from valid sampled in IDLE to the grant state.
REQ-022 In GRANT_x, data SHALL pass combinationally with zero latency:
- y_valid = x_valid, y_data = x_data, y_last = x_last;
- x_ready = y_ready;
- the other requester's ready = 0.
REQ-023 sel SHALL be 0 in IDLE and GRANT_A, and 1 in GRANT_B; sel SHALL change only on a state transition.
REQ-024 A beat counter SHALL:
- clear on entry to a grant state;
- increment on each accepted beat;
- have width $clog2(MAX_BEATS+1).
REQ-025 An accepted beat with y_last = 1 SHALL return the FSM to IDLE on the next edge, giving one idle bubble before the next grant.
REQ-026 An accepted non-last beat that brings the counter to MAX_BEATS SHALL return the FSM to IDLE and pulse err_overrun for exactly one cycle.
REQ-027 If the granted requester drops valid mid-packet, the grant SHALL be held and y_valid SHALL be 0; the other requester SHALL NOT be granted until the packet ends.
REQ-028 y_ready = 0 while the grant is held SHALL stall: state, counter and output values SHALL stay unchanged.
REQ-029 A last beat that is also beat MAX_BEATS SHALL be treated as a normal end, with err_overrun = 0.

Reset
REQ-030 While rst_n = 0 at a clock edge, the following SHALL be set:
- state = IDLE;
- last_grant = B, so A wins the first tie;
- counter = 0, err_overrun = 0.
REQ-031 Following reset, outputs SHALL be y_valid = 0, a_ready = 0, b_ready = 0, sel = 0 and y_data = A's data.
REQ-032 Reset asserted mid-packet SHALL abandon the packet; no beat SHALL be accepted in the reset cycle.

Structure
REQ-033 Package mux_arb_pkg SHALL hold:
- the state enum (IDLE, GRANT_A, GRANT_B);
- the constant SEL_A = 0 and SEL_B = 1;
- the default MAX_BEATS.
REQ-034 The WIDTH-wide data/last select SHALL be a sub-module, mux_2to1_bus, driven by sel; all control logic stays in the top module.

Verification
REQ-035 Stimulus: reset, then a_valid = b_valid = 1 with 2-beat packets (A: 0x11, 0x12; B: 0x21, 0x22), y_ready = 1.
Response: output order 0x11, 0x12, bubble, 0x21, 0x22.
REQ-036 Stimulus: B alone sends a 3-beat packet, then both request.
Response: A granted next (last_grant = B); sel goes 1 -> 0.
REQ-037 Stimulus: during an A packet, y_ready toggles 1,0,0,1.
Response: y_data is held steady while y_ready = 0; no beat is lost or duplicated; b_ready stays 0 throughout.
REQ-038 Stimulus: A sends 17 beats with no last, MAX_BEATS = 16.
Response: beats 1-16 accepted; err_overrun pulses once on the cycle after beat 16; IDLE follows; a pending B request is then granted.
REQ-039 Stimulus: rst_n = 0 during A beat 2 of 4.
Response: on the next cycle state = IDLE, sel = 0 and all readies are 0; A's request is then re-arbitrated as a fresh packet.
REQ-040 Stimulus: a_valid drops for 3 cycles mid-packet while b_valid = 1.
Response: grant stays on A; b_ready stays 0; y_valid = 0 during the gap.
